// File: rtl/inbuf_feed_ctrl.sv
// Loads a tile column-major into ROWS INBUFs (one-hot writes, 1-cycle latency, in_ready stalls upstream),
// then strobes per-row reads; diagonal skew across rows only when INBUF_FEED_SKEW_EN is defined.
module inbuf_feed_ctrl #(
    parameter int ROWS    = 4,
    parameter int WORDLEN = 8,
    parameter int VECLEN  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    input  logic [WORDLEN-1:0] in_data,
    output logic               in_ready,
    output logic [ROWS-1:0]    buf_write,
    output logic [WORDLEN-1:0] buf_din,
    output logic [ROWS-1:0]    buf_read,
    output logic               array_en,
    output logic               busy,
    output logic               done
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] SETTLE = 3'd2;
    localparam logic [2:0] STREAM = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    localparam int NWORDS = ROWS * VECLEN;
    localparam int WCW    = $clog2(NWORDS + 1);
    localparam int SCW    = $clog2(VECLEN + ROWS);
    localparam int RW     = $clog2(ROWS);
`ifdef INBUF_FEED_SKEW_EN
    localparam int SLEN   = VECLEN + ROWS - 1;
`else
    localparam int SLEN   = VECLEN;
`endif
    localparam logic [WCW-1:0] WLAST = WCW'(NWORDS - 1);
    localparam logic [SCW-1:0] SLAST = SCW'(SLEN - 1);
    localparam logic [RW-1:0]  RLAST = RW'(ROWS - 1);

    logic [2:0]      state, state_n;
    logic [WCW-1:0]  wcnt, wcnt_n;
    logic [RW-1:0]   row, row_n;
    logic [SCW-1:0]  scnt, scnt_n;
    logic [ROWS-1:0] rd_n;
    logic            accept;

    assign accept = (state == LOAD) && in_valid;

    always_comb begin
        state_n = state;
        wcnt_n  = wcnt;
        row_n   = row;
        scnt_n  = scnt;
        case (state)
            IDLE: begin
                wcnt_n = '0;
                row_n  = '0;
                if (start) state_n = LOAD;
            end
            LOAD: begin
                if (in_valid) begin
                    wcnt_n = wcnt + WCW'(1);
                    row_n  = (row == RLAST) ? '0 : row + RW'(1);
                    if (wcnt == WLAST) state_n = SETTLE;
                end
            end
            SETTLE: begin
                state_n = STREAM;
                scnt_n  = '0;
            end
            STREAM: begin
                if (scnt == SLAST) state_n = DONE;
                else               scnt_n  = scnt + SCW'(1);
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Read strobes are computed from next state so the registered output lines up with STREAM.
    always_comb begin
        rd_n = '0;
        if (state_n == STREAM) begin
`ifdef INBUF_FEED_SKEW_EN
            for (int r = 0; r < ROWS; r++)
                rd_n[r] = (int'(scnt_n) >= r) && (int'(scnt_n) < r + VECLEN);
`else
            rd_n = '1;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wcnt      <= '0;
            row       <= '0;
            scnt      <= '0;
            in_ready  <= 1'b0;
            buf_write <= '0;
            buf_din   <= '0;
            buf_read  <= '0;
            array_en  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state    <= state_n;
            wcnt     <= wcnt_n;
            row      <= row_n;
            scnt     <= scnt_n;
            in_ready <= (state_n == LOAD);
            if (accept) begin
                buf_write <= ROWS'(1) << row;
                buf_din   <= in_data;
            end else begin
                buf_write <= '0;
            end
            buf_read <= rd_n;
            array_en <= (state_n == STREAM);
            busy     <= (state_n != IDLE);
            done     <= (state_n == DONE);
        end
    end

endmodule
